// File: rtl/stack_access_ctrl.sv
// rtl/stack_access_ctrl.sv - round-robin push/pop sequencer sharing one hardware stack between two requesters
module stack_access_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  output logic             err0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full,
  output logic             busy,
  output logic             gnt_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  if (WIDTH < 1 || DEPTH < 1) begin : g_param_check
    $error("stack_access_ctrl: WIDTH and DEPTH must be positive");
  end

  logic [1:0]       r_state;
  logic             r_rr_last;
  logic             r_gnt;
  logic             r_op;
  logic             r_err;
  logic [WIDTH-1:0] r_wdata;

  logic             w_any_req;
  logic             w_gnt;
  logic             w_op;
  logic             w_err;
  logic [WIDTH-1:0] w_wdata;
  logic             w_issue;
  logic             w_ack;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_any_req = req0 | req1;
    w_gnt     = (req0 && req1) ? ~r_rr_last : req1;
    w_op      = w_gnt ? op1 : op0;
    w_wdata   = w_gnt ? wdata1 : wdata0;
    w_err     = w_op ? stk_empty : stk_full;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= S_IDLE;
      r_rr_last <= 1'b1;
      r_gnt     <= 1'b0;
      r_op      <= 1'b0;
      r_err     <= 1'b0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ISSUE;
            r_gnt     <= w_gnt;
            r_rr_last <= w_gnt;
            r_op      <= w_op;
            r_err     <= w_err;
            r_wdata   <= w_wdata;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT:  r_state <= S_ACK;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes exist only in ISSUE, so they can never be wider than one cycle.
  always_comb begin
    w_issue  = (r_state == S_ISSUE);
    w_ack    = (r_state == S_ACK);
    busy     = (r_state != S_IDLE);
    gnt_id   = busy & r_gnt;
    stk_push = w_issue & ~r_err & ~r_op;
    stk_pop  = w_issue & ~r_err & r_op;
    stk_din  = stk_push ? r_wdata : '0;
    ack0     = w_ack & ~r_gnt;
    ack1     = w_ack & r_gnt;
    err0     = ack0 & r_err;
    err1     = ack1 & r_err;
    rdata    = (w_ack && r_op && !r_err) ? stk_dout : '0;
  end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// tb/tb_stack_access_ctrl.sv - directed scoreboard bench for stack_access_ctrl with a behavioural stack
module tb_stack_access_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0, op0, req1, op1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, err0, ack1, err1;
  logic [7:0] rdata, stk_din, stk_dout;
  logic       stk_push, stk_pop, stk_empty, stk_full, busy, gnt_id;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       id;
    logic       err;
    logic [7:0] rd;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  stack_access_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
    .rdata(rdata), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Behavioural 8-deep stack with registered dout, sharing the controller reset.
  logic [7:0] mem [8];
  logic [3:0] sp;
  assign stk_empty = (sp == 4'd0);
  assign stk_full  = (sp == 4'd8);

  always @(posedge clk) begin
    if (rstn) begin
      sp       <= 4'd0;
      stk_dout <= 8'h00;
    end else if (stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= stk_din;
      sp           <= sp + 4'd1;
    end else if (stk_pop && sp > 4'd0) begin
      stk_dout <= mem[3'(sp - 4'd1)];
      sp       <= sp - 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {ack0, ack1}, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_id", {ack1, ack0}, mon_e.id ? 2'b10 : 2'b01);
          chk("ack_err", {err1, err0}, mon_e.id ? {mon_e.err, 1'b0} : {1'b0, mon_e.err});
          chk("ack_rdata", rdata, mon_e.rd);
        end
      end else begin
        chk("idle_rdata_err", {rdata, err0, err1}, 0);
      end
    end
  end

  task automatic drive(input logic id, input logic op, input logic [7:0] d);
    if (id) begin req1 = 1'b1; op1 = op; wdata1 = d; end
    else    begin req0 = 1'b1; op0 = op; wdata0 = d; end
  endtask

  task automatic release_req(input logic id);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic single(input logic id, input logic op, input logic [7:0] d,
                        input logic exp_err, input logic [7:0] exp_rd);
    exp_t e;
    int   k;
    logic got;
    e.id = id; e.err = exp_err; e.rd = exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(id, op, d);
    @(posedge clk); #1;
    chk("issue_busy", busy, 1);
    chk("issue_gnt", gnt_id, id);
    chk("issue_push", stk_push, (!op && !exp_err));
    chk("issue_pop", stk_pop, (op && !exp_err));
    chk("issue_din", stk_din, (!op && !exp_err) ? d : 8'h00);
    @(posedge clk); #1;
    chk("wait_strobes", {stk_push, stk_pop}, 0);
    got = 1'b0;
    k = 0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      got = id ? ack1 : ack0;
    end
    chk("ack_latency", k, 2);
    @(posedge clk); #1;
    release_req(id);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   cnt;
    int   k;
    rstn = 1'b1;
    req0 = 1'b0; op0 = 1'b0; wdata0 = 8'h00;
    req1 = 1'b0; op1 = 1'b0; wdata1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {ack0, ack1, err0, err1, stk_push, stk_pop, busy, gnt_id}, 0);
    chk("rst_data", {rdata, stk_din}, 0);

    single(1'b0, 1'b0, 8'hA5, 1'b0, 8'h00);
    chk("t1_not_empty", stk_empty, 0);
    single(1'b0, 1'b1, 8'h00, 1'b0, 8'hA5);
    chk("t2_empty", stk_empty, 1);

    single(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) single(1'b0, 1'b0, 8'(8'h80 + i), 1'b0, 8'h00);
    chk("t3_full", stk_full, 1);
    single(1'b0, 1'b0, 8'hEE, 1'b1, 8'h00);
    for (int i = 7; i >= 0; i--) single(i[0], 1'b1, 8'h00, 1'b0, 8'(8'h80 + i));
    chk("t3_drained", stk_empty, 1);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      e.id = i[0]; e.err = 1'b0; e.rd = 8'h00;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h30);
    drive(1'b1, 1'b0, 8'h31);
    cnt = 0;
    k = 0;
    while (cnt < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (ack0 || ack1) cnt++;
    end
    @(posedge clk); #1;
    release_req(1'b0);
    release_req(1'b1);
    chk("t4_ack_count", cnt, 4);
    single(1'b1, 1'b1, 8'h00, 1'b0, 8'h31);
    single(1'b0, 1'b1, 8'h00, 1'b0, 8'h30);
    single(1'b0, 1'b1, 8'h00, 1'b0, 8'h31);
    single(1'b1, 1'b1, 8'h00, 1'b0, 8'h30);

    single(1'b1, 1'b0, 8'h11, 1'b0, 8'h00);
    single(1'b0, 1'b0, 8'h22, 1'b0, 8'h00);
    single(1'b1, 1'b1, 8'h00, 1'b0, 8'h22);
    single(1'b0, 1'b1, 8'h00, 1'b0, 8'h11);

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h77);
    @(posedge clk); #1;
    chk("t6_issue_push", stk_push, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b0;
    release_req(1'b0);
    @(negedge clk);
    chk("t6_after_rst", {ack0, ack1, err0, err1, stk_push, stk_pop, busy, gnt_id}, 0);
    chk("t6_after_rst_data", {rdata, stk_din}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ack", {ack0, ack1, busy}, 0);
    end
    single(1'b0, 1'b0, 8'h12, 1'b0, 8'h00);
    single(1'b0, 1'b1, 8'h00, 1'b0, 8'h12);
    single(1'b1, 1'b1, 8'h00, 1'b1, 8'h00);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
